idstage_pipe: RTL and testbench
===============================

Name: idstage_pipe

Overview:
Parametrised RV32I decode stage with valid/ready handshakes on both sides and a 2-entry skid buffer, so fetch and execute can stall independently without losing instructions. It decodes a raw 32-bit instruction into riscv_pkg::instruction_t and produces fully assembled, optionally sign-extended immediates, an illegal-instruction flag and a PC passthrough. It sits between fetch and execute and supports a pipeline flush for branches and traps.

Parameters:
PC_W, 32, width of the PC passthrough field.
IMM_SEXT, 1, 1 = sign-extend immediates from their top bit (inst[31]) to 32 bits; 0 = zero-extend.
SKID_EN, 1, 1 = 2-entry skid buffer with registered ready_o; 0 = single entry with ready_o = !valid_o || ready_i.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-high.
flush_i  in  1  synchronous flush; discards all held entries.
valid_i  in  1  upstream instruction valid.
ready_o  out  1  stage can accept an instruction this cycle.
instruction_i  in  32  raw instruction word.
pc_i  in  PC_W  PC of instruction_i.
valid_o  out  1  decoded output valid.
ready_i  in  1  downstream accepts the output.
instruction_o  out  riscv_pkg::instruction_t  decoded instruction.
pc_o  out  PC_W  PC of instruction_o.
illegal_o  out  1  instruction_o is illegal; qualified by valid_o.

Behaviour:
- Handshake transfers: input on valid_i && ready_o; output on valid_o && ready_i. While valid_o=1, outputs stay stable until a transfer completes.
- Latency: accepted instruction appears on the outputs in the next cycle. There is no combinational path from instruction_i to the outputs.
- Reset (rst_i=1 at a clock edge): valid_o=0, instruction_o='0, pc_o=0, illegal_o=0, ready_o=1 in the following cycle. Reset overrides flush_i and all handshakes, including mid-stall.
- Flush (flush_i=1): both entries are invalidated and ready_o=1 in the next cycle. Any instruction offered in the same cycle is dropped. Flush has priority over acceptance.
- Buffer FSM (SKID_EN=1), states EMPTY, ONE, TWO; the output is driven from the main register.
  - EMPTY: on accept -> ONE.
  - ONE: accept without output transfer -> TWO (the new instruction goes into the skid register). Accept with output transfer -> ONE (main register reloaded). Output transfer only -> EMPTY.
  - TWO: ready_o=0. On output transfer, skid moves to main -> ONE.
  - ready_o is a register: equals (next state != TWO).
- SKID_EN=0: single entry. ready_o = !valid_o || ready_i. Simultaneous input and output transfer reloads the entry.
- Decode (the decoded word is stored in the buffer, not the raw word):
  - opcode = inst[6:2]; all other fields default to 0; is_imm=0.
  - R (OP_ALU): rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7=[31:25].
  - I (OP_ALU_IMM, OP_LOAD, OP_JALR): rd, f3, rs1; imm=ext(inst[31:20]); is_imm=1.
  - S (OP_STORE): f3, rs1, rs2; imm=ext({inst[31:25],inst[11:7]}); is_imm=1.
  - B (OP_BRANCH): f3, rs1, rs2; imm=ext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); is_imm=1.
  - U (OP_LUI, OP_AUIPC): rd; imm={inst[31:12],12'b0}; is_imm=1. No extension is applied.
  - J (OP_JAL): rd; imm=ext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); is_imm=1.
  - OP_MISC_MEM, OP_SYSTEM: rd, f3, rs1, imm=ext(inst[31:20]); is_imm=0.
  - illegal_o=1 if inst[1:0]!=2'b11 or the opcode is not listed above. In that case only the opcode field is populated.
- Output fields are held at '0 while valid_o=0.

Test Plan:
- Reset then push 0xFFF10093 (addi x1,x2,-1), ready_i=1 -> next cycle valid_o=1, opcode=5'b00100, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF, is_imm=1. With IMM_SEXT=0 -> imm=0x00000FFF.
- Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, rs1=rs2=0, is_imm=1, illegal_o=0.
- Push 0x123452B7 (lui x5,0x12345) then 0x00000000 -> first output rd=5, imm=0x12345000. Second output illegal_o=1.
- ready_i=0, offer 3 instructions back-to-back with PCs 0x0/0x4/0x8 -> two accepted, ready_o=0 from the 3rd cycle. Raise ready_i -> outputs PC 0x0, 0x4, then 0x8 with no loss or duplication.
- In state TWO assert flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1, offered instruction dropped.
- Assert rst_i while stalled in TWO -> next cycle valid_o=0, instruction_o='0, ready_o=1. A following push emits normally after 1 cycle.

Source files
------------

// File: rtl/idstage_pipe.sv
// RV32I decode stage: decodes raw instruction words into riscv_pkg::instruction_t
// behind valid/ready handshakes, with an optional 2-entry skid buffer.
package riscv_pkg;

    typedef enum logic [4:0] {
        OP_LOAD     = 5'b00000,
        OP_MISC_MEM = 5'b00011,
        OP_ALU_IMM  = 5'b00100,
        OP_AUIPC    = 5'b00101,
        OP_STORE    = 5'b01000,
        OP_ALU      = 5'b01100,
        OP_LUI      = 5'b01101,
        OP_BRANCH   = 5'b11000,
        OP_JALR     = 5'b11001,
        OP_JAL      = 5'b11011,
        OP_SYSTEM   = 5'b11100
    } opcode_e;

    // opcode is plain logic so unknown opcodes of illegal words can be reported as-is
    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        is_imm;
    } instruction_t;

endpackage

module idstage_pipe
    import riscv_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter bit IMM_SEXT = 1'b1,
    parameter bit SKID_EN  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instruction_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output instruction_t    instruction_o,
    output logic [PC_W-1:0] pc_o,
    output logic            illegal_o
);

    typedef struct packed {
        instruction_t    ins;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e      state;
    entry_t      main_q;
    entry_t      skid_q;
    entry_t      dec;
    logic        ready_q;
    logic [31:0] fill;
    logic        accept;
    logic        out_xfer;

    assign valid_o       = (state != EMPTY);
    assign ready_o       = SKID_EN ? ready_q : (!valid_o || ready_i);
    assign accept        = valid_i && ready_o;
    assign out_xfer      = valid_o && ready_i;
    assign instruction_o = main_q.ins;
    assign pc_o          = main_q.pc;
    assign illegal_o     = main_q.illegal;

    // NOTE: every output of an always_comb gets a default first, so no path leaves a latch.
    always_comb begin
        fill              = IMM_SEXT ? {32{instruction_i[31]}} : 32'h0;
        dec               = '0;
        dec.pc            = pc_i;
        dec.ins.opcode    = instruction_i[6:2];
        if (instruction_i[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (instruction_i[6:2])
                OP_ALU: begin
                    dec.ins.rd  = instruction_i[11:7];
                    dec.ins.f3  = instruction_i[14:12];
                    dec.ins.rs1 = instruction_i[19:15];
                    dec.ins.rs2 = instruction_i[24:20];
                    dec.ins.f7  = instruction_i[31:25];
                end
                OP_ALU_IMM, OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
                    dec.ins.rd     = instruction_i[11:7];
                    dec.ins.f3     = instruction_i[14:12];
                    dec.ins.rs1    = instruction_i[19:15];
                    dec.ins.imm    = {fill[31:12], instruction_i[31:20]};
                    // fence/system carry the raw I-field but are not ALU immediates
                    dec.ins.is_imm = !(instruction_i[6:2] inside {OP_MISC_MEM, OP_SYSTEM});
                end
                OP_STORE: begin
                    dec.ins.f3     = instruction_i[14:12];
                    dec.ins.rs1    = instruction_i[19:15];
                    dec.ins.rs2    = instruction_i[24:20];
                    dec.ins.imm    = {fill[31:12], instruction_i[31:25], instruction_i[11:7]};
                    dec.ins.is_imm = 1'b1;
                end
                OP_BRANCH: begin
                    dec.ins.f3     = instruction_i[14:12];
                    dec.ins.rs1    = instruction_i[19:15];
                    dec.ins.rs2    = instruction_i[24:20];
                    dec.ins.imm    = {fill[31:13], instruction_i[31], instruction_i[7],
                                      instruction_i[30:25], instruction_i[11:8], 1'b0};
                    dec.ins.is_imm = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    dec.ins.rd     = instruction_i[11:7];
                    dec.ins.imm    = {instruction_i[31:12], 12'h000};
                    dec.ins.is_imm = 1'b1;
                end
                OP_JAL: begin
                    dec.ins.rd     = instruction_i[11:7];
                    dec.ins.imm    = {fill[31:21], instruction_i[31], instruction_i[19:12],
                                      instruction_i[20], instruction_i[30:21], 1'b0};
                    dec.ins.is_imm = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            // NOTE: both entries are cleared, not just invalidated, because idle outputs must read '0.
            state   <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        main_q <= dec;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    ready_q <= 1'b1;
                    if (accept && !out_xfer) begin
                        skid_q  <= dec;
                        state   <= TWO;
                        ready_q <= 1'b0;
                    end else if (accept) begin
                        main_q <= dec;
                    end else if (out_xfer) begin
                        main_q <= '0;
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        skid_q  <= '0;
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idstage_pipe.sv
// Bench for idstage_pipe: directed scenarios plus random traffic, checked against
// a queue-based model with an arithmetic reference decoder.
module tb_idstage_pipe;
    import riscv_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i, flush_i, valid_i, ready_i;
    logic [31:0]  instruction_i, pc_i;
    logic         ready_o, valid_o, illegal_o;
    instruction_t instruction_o;
    logic [31:0]  pc_o;
    logic         z_ready_o, z_valid_o, z_illegal_o;
    instruction_t z_instruction_o;
    logic [31:0]  z_pc_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    idstage_pipe #(.PC_W(32), .IMM_SEXT(1'b1), .SKID_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .instruction_i(instruction_i), .pc_i(pc_i),
        .valid_o(valid_o), .ready_i(ready_i), .instruction_o(instruction_o),
        .pc_o(pc_o), .illegal_o(illegal_o)
    );

    // zero-extending twin fed with identical stimulus
    idstage_pipe #(.PC_W(32), .IMM_SEXT(1'b0), .SKID_EN(1'b1)) dut_z (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(z_ready_o), .instruction_i(instruction_i), .pc_i(pc_i),
        .valid_o(z_valid_o), .ready_i(ready_i), .instruction_o(z_instruction_o),
        .pc_o(z_pc_o), .illegal_o(z_illegal_o)
    );

    typedef struct {
        instruction_t s;
        instruction_t z;
        logic [31:0]  pc;
        logic         ill;
    } exp_t;

    exp_t q[$];
    bit   m_ready = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_illegal(input logic [31:0] w);
        int unsigned op = int'(w[6:2]);
        return (w[1:0] != 2'b11) ||
               !(op inside {'h00, 'h03, 'h04, 'h05, 'h08, 'h0c, 'h0d, 'h18, 'h19, 'h1b, 'h1c});
    endfunction

    function automatic instruction_t ref_decode(input logic [31:0] w, input bit sext);
        instruction_t r = '0;
        int unsigned  op = int'(w[6:2]);
        int unsigned  v = 0;
        int unsigned  bits = 0;
        r.opcode = w[6:2];
        if (ref_illegal(w)) return r;
        if (op inside {'h0c, 'h04, 'h00, 'h19, 'h0d, 'h05, 'h1b, 'h03, 'h1c}) r.rd = w[11:7];
        if (op inside {'h0c, 'h04, 'h00, 'h19, 'h08, 'h18, 'h03, 'h1c}) begin
            r.f3  = w[14:12];
            r.rs1 = w[19:15];
        end
        if (op inside {'h0c, 'h08, 'h18}) r.rs2 = w[24:20];
        if (op == 'h0c) r.f7 = w[31:25];
        if (op inside {'h04, 'h00, 'h19, 'h03, 'h1c}) begin
            v = int'(w[31:20]); bits = 12;
        end else if (op == 'h08) begin
            v = int'(w[31:25]) * 32 + int'(w[11:7]); bits = 12;
        end else if (op == 'h18) begin
            v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            bits = 13;
        end else if (op == 'h1b) begin
            v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            bits = 21;
        end else if (op inside {'h0d, 'h05}) begin
            v = int'(w[31:12]) * 4096;
        end
        if (sext && w[31] && bits != 0) v = v - (32'd1 << bits);
        r.imm    = v;
        r.is_imm = (op != 'h0c) && (op != 'h03) && (op != 'h1c);
        return r;
    endfunction

    task automatic model_update();
        bit out, acc;
        if (rst_i || flush_i) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            out = (q.size() > 0) && ready_i;
            acc = valid_i && m_ready;
            if (out) void'(q.pop_front());
            if (acc) q.push_back('{s: ref_decode(instruction_i, 1'b1), z: ref_decode(instruction_i, 1'b0),
                                   pc: pc_i, ill: ref_illegal(instruction_i)});
            m_ready = (q.size() < 2);
        end
    endtask

    task automatic compare_outputs();
        exp_t e = '{s: '0, z: '0, pc: '0, ill: 1'b0};
        if (q.size() > 0) e = q[0];
        check("valid",   valid_o,         q.size() > 0);
        check("ready",   ready_o,         m_ready);
        check("instr",   instruction_o,   e.s);
        check("pc",      pc_o,            e.pc);
        check("illegal", illegal_o,       e.ill);
        check("z_valid", z_valid_o,       q.size() > 0);
        check("z_instr", z_instruction_o, e.z);
    endtask

    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic rs);
        valid_i = v; instruction_i = inst; pc_i = pc;
        ready_i = rdy; flush_i = fl; rst_i = rs;
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        compare_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] ops [11] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0c,
                                 5'h0d, 5'h18, 5'h19, 5'h1b, 5'h1c};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 99) < 85) w[6:2] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 99) < 90) w[1:0] = 2'b11;
        return w;
    endfunction

    initial begin
        valid_i = 0; instruction_i = 0; pc_i = 0; ready_i = 0; flush_i = 0; rst_i = 0;
        @(negedge clk_i);

        // reset state
        step(0, 0, 0, 1, 0, 1);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_instr", instruction_o, 64'h0);

        // addi x1,x2,-1
        step(1, 32'hFFF10093, 32'h100, 1, 0, 0);
        check("addi_valid",  valid_o, 1'b1);
        check("addi_opcode", instruction_o.opcode, 5'b00100);
        check("addi_rd",     instruction_o.rd, 5'd1);
        check("addi_rs1",    instruction_o.rs1, 5'd2);
        check("addi_imm",    instruction_o.imm, 32'hFFFFFFFF);
        check("addi_is_imm", instruction_o.is_imm, 1'b1);
        check("addi_zimm",   z_instruction_o.imm, 32'h00000FFF);

        // beq x0,x0,-4
        step(1, 32'hFE000EE3, 32'h104, 1, 0, 0);
        check("beq_imm",     instruction_o.imm, 32'hFFFFFFFC);
        check("beq_illegal", illegal_o, 1'b0);

        // lui x5,0x12345 then an all-zero word
        step(1, 32'h123452B7, 32'h108, 1, 0, 0);
        check("lui_rd",  instruction_o.rd, 5'd5);
        check("lui_imm", instruction_o.imm, 32'h12345000);
        step(1, 32'h00000000, 32'h10C, 1, 0, 0);
        check("zero_illegal", illegal_o, 1'b1);
        step(0, 0, 0, 1, 0, 0);

        // stall with three offers, then drain
        step(1, 32'h00000013, 32'h0, 0, 0, 0);
        step(1, 32'h00000013, 32'h4, 0, 0, 0);
        step(1, 32'h00000013, 32'h8, 0, 0, 0);
        check("stall_ready", ready_o, 1'b0);
        check("stall_pc0",   pc_o, 32'h0);
        step(1, 32'h00000013, 32'h8, 1, 0, 0);
        check("drain_pc4", pc_o, 32'h4);
        step(1, 32'h00000013, 32'h8, 1, 0, 0);
        check("drain_pc8", pc_o, 32'h8);
        step(0, 0, 0, 1, 0, 0);
        check("drain_empty", valid_o, 1'b0);

        // flush while full, with an instruction on offer
        step(1, 32'h00000013, 32'h20, 0, 0, 0);
        step(1, 32'h00000013, 32'h24, 0, 0, 0);
        step(1, 32'h00000013, 32'h28, 0, 1, 0);
        check("flush_valid", valid_o, 1'b0);
        check("flush_ready", ready_o, 1'b1);
        step(0, 0, 0, 1, 0, 0);
        check("flush_drop", valid_o, 1'b0);

        // reset while full, then a normal push
        step(1, 32'h00000013, 32'h30, 0, 0, 0);
        step(1, 32'h00000013, 32'h34, 0, 0, 0);
        step(1, 32'h00000013, 32'h38, 0, 0, 1);
        check("rst2_valid", valid_o, 1'b0);
        check("rst2_instr", instruction_o, 64'h0);
        check("rst2_ready", ready_o, 1'b1);
        step(1, 32'hFFF10093, 32'h40, 1, 0, 0);
        check("rst2_push", valid_o, 1'b1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 70, rand_inst(), $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 2);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
